// File: rtl/fht_input_loader.sv
// fht_input_loader: collects one frame of N = 2^(A_BIT+2) samples and writes each one into
// the four FHT data banks at its bit-reversed position. Once the frame is complete it
// requests a transform. It then holds off input until the core reports done again.
module fht_input_loader #(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iVALID,
    input  logic [D_BIT-1:0] iDATA,
    output logic             oREADY,
    input  logic             iRDY,
    output logic             oSTART,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA,
    output logic             oLOADING,
    output logic             oERR
);

    localparam int K_BIT = A_BIT + 2;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoad     = 3'd1;
    localparam logic [2:0] StStart    = 3'd2;
    localparam logic [2:0] StWaitBusy = 3'd3;
    localparam logic [2:0] StBusy     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [K_BIT-1:0] k_q, k_d;
    logic [K_BIT-1:0] k_rev;
    logic [3:0]       tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [3:0]       we_q, we_d;
    logic [A_BIT-1:0] addr_q;
    logic [D_BIT-1:0] data_q;
    logic             accept;

    // Ready depends only on state so upstream never sees a combinational loop through iVALID.
    assign accept = iVALID && (state_q == StLoad);

    // Bit-reverse the sample index: low two bits pick the bank, the rest form the address.
    always_comb begin
        k_rev = '0;
        for (int i = 0; i < K_BIT; i++) begin
            k_rev[i] = k_q[K_BIT-1-i];
        end
    end

    // Next-state logic for the frame sequencer, sample index and busy timeout.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (iRDY) state_d = StLoad;
            end
            StLoad: begin
                if (accept) begin
                    k_d = k_q + 1'b1;
                    // Last sample of the frame: the final write and oSTART share a cycle.
                    if (k_q == {K_BIT{1'b1}}) state_d = StStart;
                end
            end
            StStart: begin
                tmo_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!iRDY) begin
                    state_d = StBusy;
                end else if (tmo_q == 4'd7) begin
                    // Core never acknowledged the start; flag it and go back to waiting.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            StBusy: begin
                if (iRDY) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // Decode the one-hot bank write enable for an accepted sample.
    always_comb begin
        we_d = 4'b0000;
        if (accept) we_d = 4'b0001 << k_rev[1:0];
    end

    // Sequencer state registers with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q <= StIdle;
            k_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Registered bank write port; address and data hold their last value between writes.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            we_q   <= 4'b0000;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= we_d;
            if (accept) begin
                addr_q <= k_rev[K_BIT-1:2];
                data_q <= iDATA;
            end
        end
    end

    assign oREADY   = (state_q == StLoad);
    assign oLOADING = (state_q == StLoad);
    assign oSTART   = (state_q == StStart);
    assign oWE_0    = we_q[0];
    assign oWE_1    = we_q[1];
    assign oWE_2    = we_q[2];
    assign oWE_3    = we_q[3];
    assign oADDR_WR = addr_q;
    assign oDATA    = data_q;
    assign oERR     = err_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Bench for fht_input_loader with A_BIT=2 (N=16): randomized samples and gaps checked against
// a bit-reversal placement model computed with plain arithmetic.
module tb_fht_input_loader;

    localparam int unsigned A_BIT = 2;
    localparam int unsigned D_BIT = 16;
    localparam int unsigned K_BIT = A_BIT + 2;
    localparam int unsigned N     = 1 << K_BIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [D_BIT-1:0] din;
    logic             rdy;
    logic             ready;
    logic             start;
    logic             we_0, we_1, we_2, we_3;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;
    logic             loading;
    logic             err;
    logic [3:0]       we;

    int checks = 0;
    int errors = 0;

    int unsigned      mk = 0;
    int unsigned      n_acc, n_wr;
    logic [3:0]       obs_we   [N];
    logic [A_BIT-1:0] obs_addr [N];
    logic [D_BIT-1:0] obs_data [N];

    assign we = {we_3, we_2, we_1, we_0};

    fht_input_loader #(
        .A_BIT (A_BIT),
        .D_BIT (D_BIT)
    ) dut (
        .iCLK     (clk),
        .iRESET   (rst_n),
        .iVALID   (valid),
        .iDATA    (din),
        .oREADY   (ready),
        .iRDY     (rdy),
        .oSTART   (start),
        .oWE_0    (we_0),
        .oWE_1    (we_1),
        .oWE_2    (we_2),
        .oWE_3    (we_3),
        .oADDR_WR (addr),
        .oDATA    (data),
        .oLOADING (loading),
        .oERR     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned brev(input int unsigned k);
        int unsigned r = 0;
        int unsigned v = k;
        for (int i = 0; i < int'(K_BIT); i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic int bank_of(input logic [3:0] w);
        case (w)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Streams n accepted samples, gap_pct percent idle cycles; model predicts every write.
    task automatic drive_samples(input int unsigned n, input int unsigned gap_pct,
                                 input bit seq_data);
        int unsigned sent = 0;
        int unsigned budget = 0;
        int unsigned r;
        bit v;
        logic [D_BIT-1:0] d;
        logic [3:0] exp_we;
        while (sent < n) begin
            if (budget > n * 20 + 50) begin
                checks++; errors++;
                $display("FAIL load_budget got %0d accepts want %0d", sent, n);
                valid = 1'b0;
                return;
            end
            budget++;
            v = ($urandom_range(0, 99) >= gap_pct);
            d = seq_data ? D_BIT'(mk + 100) : D_BIT'($urandom);
            valid = v;
            din = d;
            checks++;
            if (ready !== 1'b1 || loading !== 1'b1) begin
                errors++;
                $display("FAIL load_ready got %b/%b want 1/1", ready, loading);
            end
            cycle();
            if (we !== 4'b0000) n_wr++;
            if (v) begin
                r = brev(mk);
                exp_we = 4'b0001 << (r % 4);
                obs_we[mk] = we;
                obs_addr[mk] = addr;
                obs_data[mk] = data;
                checks++;
                if (we !== exp_we || addr !== A_BIT'(r / 4) || data !== d) begin
                    errors++;
                    $display("FAIL write_k%0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                             mk, we, addr, data, exp_we, r / 4, d);
                end
                n_acc++;
                mk = (mk + 1) % N;
                sent++;
                checks++;
                if (start !== (mk == 0)) begin
                    errors++;
                    $display("FAIL start_pulse got %b want %b", start, (mk == 0));
                end
            end else begin
                checks++;
                if (we !== 4'b0000 || start !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_write got we=%b start=%b want 0000/0", we, start);
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; valid = 1'b0; din = '0;
        repeat (3) cycle();
        checks++;
        if (ready !== 1'b0 || we !== 4'b0000 || start !== 1'b0 || err !== 1'b0 ||
            loading !== 1'b0 || addr !== '0 || data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b we=%b st=%b err=%b ld=%b want all 0",
                     ready, we, start, err, loading);
        end
        rst_n = 1'b1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 0", ready);
        end
        cycle();
        checks++;
        if (ready !== 1'b1 || we !== 4'b0000 || start !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_load got rdy=%b we=%b st=%b err=%b want 1/0000/0/0",
                     ready, we, start, err);
        end
        mk = 0;
    endtask

    task automatic test_frame_order();
        drive_samples(N, 0, 1'b1);
        checks++;
        if (obs_we[1] !== 4'b0001 || obs_addr[1] !== 2'd2 || obs_data[1] !== 16'd101) begin
            errors++;
            $display("FAIL order_k1 got %b/%0d/%0d want 0001/2/101",
                     obs_we[1], obs_addr[1], obs_data[1]);
        end
        checks++;
        if (obs_we[2] !== 4'b0001 || obs_addr[2] !== 2'd1) begin
            errors++;
            $display("FAIL order_k2 got %b/%0d want 0001/1", obs_we[2], obs_addr[2]);
        end
        checks++;
        if (obs_we[4] !== 4'b0100 || obs_addr[4] !== 2'd0) begin
            errors++;
            $display("FAIL order_k4 got %b/%0d want 0100/0", obs_we[4], obs_addr[4]);
        end
        checks++;
        if (obs_we[15] !== 4'b1000 || obs_addr[15] !== 2'd3 || obs_data[15] !== 16'd115) begin
            errors++;
            $display("FAIL order_k15 got %b/%0d/%0d want 1000/3/115",
                     obs_we[15], obs_addr[15], obs_data[15]);
        end
    endtask

    // Entered in the oSTART cycle: core goes busy three cycles later for 40 cycles.
    task automatic test_busy_stall();
        valid = 1'b1;
        din = D_BIT'($urandom);
        repeat (3) begin
            cycle();
            checks++;
            if (ready !== 1'b0 || we !== 4'b0000 || start !== 1'b0) begin
                errors++;
                $display("FAIL wait_busy_quiet got rdy=%b we=%b st=%b want 0/0000/0",
                         ready, we, start);
            end
        end
        rdy = 1'b0;
        repeat (40) begin
            cycle();
            checks++;
            if (ready !== 1'b0 || we !== 4'b0000 || err !== 1'b0) begin
                errors++;
                $display("FAIL busy_stall got rdy=%b we=%b err=%b want 0/0000/0", ready, we, err);
            end
        end
        rdy = 1'b1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_release_early got %b want 0", ready);
        end
        cycle();
        checks++;
        if (ready !== 1'b1 || we !== 4'b0000) begin
            errors++;
            $display("FAIL busy_release got rdy=%b we=%b want 1/0000", ready, we);
        end
        valid = 1'b0;
    endtask

    task automatic test_timeout();
        drive_samples(N, 0, 1'b0);
        valid = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            cycle();
            checks++;
            if (err !== (j >= 9) || ready !== 1'b0 || we !== 4'b0000) begin
                errors++;
                $display("FAIL timeout_c%0d got err=%b rdy=%b we=%b want err=%b rdy=0 we=0000",
                         j, err, ready, we, (j >= 9));
            end
        end
        cycle();
        checks++;
        if (ready !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_reload got rdy=%b err=%b want 1/1", ready, err);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        drive_samples(5, 0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        rst_n = 1'b0;
        cycle();
        checks++;
        if (err !== 1'b0 || ready !== 1'b0 || we !== 4'b0000) begin
            errors++;
            $display("FAIL midframe_reset got err=%b rdy=%b we=%b want 0/0/0000", err, ready, we);
        end
        rst_n = 1'b1;
        cycle();
        mk = 0;
        drive_samples(1, 0, 1'b0);
        checks++;
        if (obs_we[0] !== 4'b0001 || obs_addr[0] !== 2'd0) begin
            errors++;
            $display("FAIL restart_k0 got %b/%0d want 0001/0", obs_we[0], obs_addr[0]);
        end
    endtask

    task automatic test_gaps();
        bit visited [N];
        int unsigned distinct = 0;
        int b;
        n_acc = 0; n_wr = 0;
        drive_samples(N - 1, 40, 1'b0);
        rdy = 1'b0;
        cycle();
        cycle();
        rdy = 1'b1;
        cycle();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_reload got %b want 1", ready);
        end
        for (int i = 0; i < int'(N); i++) obs_we[i] = 4'b0000;
        drive_samples(N, 50, 1'b0);
        checks++;
        if (n_wr !== n_acc || n_acc !== 2 * N - 1) begin
            errors++;
            $display("FAIL gap_counts got writes=%0d accepts=%0d want %0d/%0d",
                     n_wr, n_acc, 2 * N - 1, 2 * N - 1);
        end
        for (int i = 0; i < int'(N); i++) visited[i] = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            b = bank_of(obs_we[i]);
            if (b >= 0 && !visited[b + 4 * int'(obs_addr[i])]) begin
                visited[b + 4 * int'(obs_addr[i])] = 1'b1;
                distinct++;
            end
        end
        checks++;
        if (distinct !== N) begin
            errors++;
            $display("FAIL gap_coverage got %0d positions want %0d", distinct, N);
        end
    endtask

    initial begin
        test_reset();
        test_frame_order();
        test_busy_stall();
        test_timeout();
        test_reset_midframe();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
